loadable_memory: RTL and testbench
==================================

# loadable_memory

Parametrised successor to the 16×8 bus RAM: a 2^A × N word store with its own memory address register (MAR) and a tri-state port onto the shared system bus. It also has a streaming program loader that replaces the DIP-switch address/data entry. In run mode the control word (mi, ri, ro_) moves data between bus, MAR and memory. In program mode a valid/ready byte stream is written to consecutive addresses starting at 0, and a done flag is raised at the end.

## Interface
- N, 8, data/bus width in bits (≥4)
- A, 4, address width; depth = 2^A words (1 ≤ A ≤ N)
- clk  in  1  system clock; all state changes on rising edge
- clr_  in  1  asynchronous, active-low reset
- bus  inout  N  shared tri-state system bus
- mi  in  1  MAR in: MAR ← bus[A-1:0] at the edge (run mode only)
- ri  in  1  RAM in: mem[MAR] ← bus at the edge (run mode only)
- ro_  in  1  RAM out, active-low: drive mem[MAR] onto bus (run mode only)
- prog_  in  1  0 = program mode, 1 = run mode
- ld_dat  in  N  loader data word
- ld_valid  in  1  ld_dat is valid this cycle
- ld_last  in  1  qualifies the final word of a load; meaningful only with ld_valid
- ld_ready  out  1  loader will accept a word this cycle
- ld_done  out  1  load sequence complete
- marval  out  A  current MAR (debug)
- memval  out  N  mem[MAR] (debug); continuous
- ld_cksum  out  N  running checksum of loaded words (present only with LDR_CKSUM_EN)

## Operation
- Loader FSM has three states: RUN, LOAD, DONE.
- RUN → LOAD when prog_ is sampled 0. Entry clears ld_addr to 0 and ld_cksum to 0.
- LOAD: ld_ready = 1.
  - A word is accepted on a cycle with ld_valid & ld_ready: mem[ld_addr] ← ld_dat, then ld_addr+1.
  - LOAD → DONE when the accepted word has ld_last = 1 or ld_addr = 2^A−1.
- DONE: ld_ready = 0, ld_done = 1. Further ld_valid is ignored.
- LOAD or DONE → RUN when prog_ is sampled 1. ld_done clears. A load abandoned mid-way keeps the words already written.
- Run mode (state RUN):
  - bus is driven with mem[MAR] while ro_ = 0; otherwise the port is high-Z.
  - ri with ro_ = 0 is a self-copy. The write is suppressed.
  - mi and ri on the same edge: the write uses the old MAR; MAR updates on the same edge.
- Program mode (LOAD/DONE):
  - mi, ri and ro_ are ignored.
  - The bus is never driven.
  - MAR holds its value.
- memval = mem[MAR] and marval = MAR in every state.
- ld_addr is A bits wide and never wraps; the final address forces DONE.

## Timing
- Reset (clr_ = 0, asynchronous) gives:
  - state = RUN, MAR = 0, ld_addr = 0
  - ld_ready = 0, ld_done = 0, ld_cksum = 0
  - bus high-Z
  - memory contents not initialised
- Read is asynchronous, like the 74189: memval and the bus drive follow MAR or memory changes with no clock latency.
- Write latency: one edge. A write of X to address k is visible on memval the cycle after, if MAR = k.
- prog_ is sampled synchronously. ld_ready rises the cycle after prog_ is first seen low. ld_done rises the cycle after the final accept.
- Throughput: one word per cycle in LOAD.
- clr_ asserted mid-load aborts the load immediately. Words already written stay in memory.

## Configuration
- LDR_CKSUM_EN defined:
  - ld_cksum port present.
  - On each accepted word, ld_cksum ← ld_cksum + ld_dat mod 2^N.
  - The value is held through DONE and RUN until the next LOAD entry or reset.
- LDR_CKSUM_EN undefined:
  - No ld_cksum port and no adder.
  - All other behaviour is identical.

## Structure
- Shared package kwan_mem_pkg holds the loader state enum ld_state_t (RUN, LOAD, DONE) and the debug-print helper constants.
- One sub-module, mem_array:
  - 2^A × N registers, one synchronous write port, one asynchronous read port.
  - Write-port address/data are muxed by the top between MAR/bus and ld_addr/ld_dat.
- The top holds the FSM, MAR, ld_addr, checksum and tri-state driver.

## Test plan
- Reset then run write:
  - Stimulus: clr_ pulse; bus = 8'h1E with mi; bus = 8'h3F with ri.
  - Required: marval = 4'hE, memval = 8'h3F.
  - Then ro_ = 0 drives 8'h3F on the bus; ro_ = 1 gives high-Z.
- Stream load of {8'h1E, 8'h2F, 8'hE0}, ld_last on the 3rd word:
  - Required: ld_ready asserted a cycle after prog_ falls; ld_done asserted the cycle after the 3rd accept.
  - Required in run mode: mem[0..2] read back as 1E, 2F, E0.
  - With LDR_CKSUM_EN: ld_cksum = 8'h2D.
- Full-depth load, 16 words, ld_last never asserted:
  - Required: DONE after word 15; ld_ready = 0.
  - A 17th ld_valid is ignored and mem[0] is unchanged.
- ld_valid gaps and abandon:
  - Stimulus: ld_valid toggled every other cycle; then prog_ = 1 after 5 words.
  - Required: exactly 5 writes; return to RUN; ld_done = 0.
- Run controls during program mode:
  - Stimulus: mi, ri and ro_ = 0 asserted during LOAD.
  - Required: MAR and memory unchanged; bus high-Z.
- Same-edge mi + ri:
  - Stimulus: MAR = 2, bus = 8'h55.
  - Required: mem[2] = 8'h55 and MAR = 5.
- clr_ during LOAD:
  - Required: ld_ready drops immediately.
  - Required: words written before the reset are retained.

Source files
------------

// File: rtl/kwan_mem_pkg.sv
// kwan_mem_pkg: loader state type and debug-print helpers shared by loadable_memory and its bench.
package kwan_mem_pkg;
  typedef enum logic [1:0] {RUN, LOAD, DONE} ld_state_t;
  localparam int LD_STATE_NAME_W = 4;
  function automatic string ld_state_name(input ld_state_t s);
    return s == RUN ? "RUN" : s == LOAD ? "LOAD" : s == DONE ? "DONE" : "????";
  endfunction
endpackage

// File: rtl/loadable_memory_mem_array.sv
// mem_array: 2^A x N register file, one synchronous write port, one asynchronous read port.
module mem_array #(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [A-1:0] i_waddr,
  input  logic [N-1:0] i_wdata,
  input  logic [A-1:0] i_raddr,
  output logic [N-1:0] o_rdata
);
  logic [N-1:0] r_mem [2**A];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/loadable_memory.sv
// loadable_memory: bus RAM with MAR, tri-state bus port and a valid/ready stream loader.
// Defining LDR_CKSUM_EN adds the ld_cksum port and its running-sum register.
module loadable_memory
  import kwan_mem_pkg::*;
#(
  parameter int N = 8,
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         clr_,
  inout  wire  [N-1:0] bus,
  input  logic         mi,
  input  logic         ri,
  input  logic         ro_,
  input  logic         prog_,
  input  logic [N-1:0] ld_dat,
  input  logic         ld_valid,
  input  logic         ld_last,
  output logic         ld_ready,
  output logic         ld_done,
  output logic [A-1:0] marval,
  output logic [N-1:0] memval
`ifdef LDR_CKSUM_EN
  ,
  output logic [N-1:0] ld_cksum
`endif
);
  ld_state_t    r_state;
  logic [A-1:0] r_mar;
  logic [A-1:0] r_ld_addr;
  logic         r_ready;
  logic         r_done;
  logic         w_run;
  logic         w_accept;
  logic         w_run_wr;
  logic         w_last_addr;
  logic         w_load_entry;
  logic [N-1:0] w_rdata;

  assign w_run        = r_state == RUN;
  assign w_accept     = r_ready & ld_valid;
  // ri together with ro_=0 would just copy mem[MAR] onto itself, so it is dropped
  assign w_run_wr     = w_run & ri & ro_;
  assign w_last_addr  = &r_ld_addr;
  assign w_load_entry = w_run & ~prog_;

  mem_array #(.N(N), .A(A)) u_mem (
    .clk    (clk),
    .i_we   (w_accept | w_run_wr),
    .i_waddr(w_accept ? r_ld_addr : r_mar),
    .i_wdata(w_accept ? ld_dat : bus),
    .i_raddr(r_mar),
    .o_rdata(w_rdata)
  );

  assign bus      = (w_run & ~ro_) ? w_rdata : {N{1'bz}};
  assign memval   = w_rdata;
  assign marval   = r_mar;
  assign ld_ready = r_ready;
  assign ld_done  = r_done;

  always_ff @(posedge clk or negedge clr_)
    if (!clr_) begin
      r_state   <= RUN;
      r_mar     <= '0;
      r_ld_addr <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        RUN:
          if (!prog_) begin
            r_state   <= LOAD;
            r_ld_addr <= '0;
            r_ready   <= 1'b1;
          end else if (mi) r_mar <= bus[A-1:0];
        LOAD: begin
          // the final address saturates instead of wrapping; it forces DONE anyway
          if (ld_valid && !w_last_addr) r_ld_addr <= r_ld_addr + 1'b1;
          if (prog_) begin
            r_state <= RUN;
            r_ready <= 1'b0;
          end else if (ld_valid && (ld_last || w_last_addr)) begin
            r_state <= DONE;
            r_ready <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE:
          if (prog_) begin
            r_state <= RUN;
            r_done  <= 1'b0;
          end
        default: r_state <= RUN;
      endcase
    end

`ifdef LDR_CKSUM_EN
  logic [N-1:0] r_cksum;
  always_ff @(posedge clk or negedge clr_)
    if (!clr_) r_cksum <= '0;
    else if (w_load_entry) r_cksum <= '0;
    else if (w_accept) r_cksum <= r_cksum + ld_dat;
  assign ld_cksum = r_cksum;
`endif
endmodule

// File: tb/tb_loadable_memory.sv
// tb_loadable_memory: directed self-checking bench for loadable_memory (N=8, A=4).
module tb_loadable_memory;
  logic       clk = 1'b0;
  logic       clr_ = 1'b0;
  logic       mi = 1'b0, ri = 1'b0, ro_ = 1'b1, prog_ = 1'b1;
  logic [7:0] ld_dat = '0;
  logic       ld_valid = 1'b0, ld_last = 1'b0;
  logic       ld_ready, ld_done;
  logic [3:0] marval;
  logic [7:0] memval;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_val = '0;
  wire  [7:0] bus;
  int         checks = 0;
  int         errors = 0;
`ifdef LDR_CKSUM_EN
  logic [7:0] ld_cksum;
`endif

  assign bus = tb_drv ? tb_val : 8'bzzzz_zzzz;

  loadable_memory #(.N(8), .A(4)) dut (
    .clk(clk), .clr_(clr_), .bus(bus), .mi(mi), .ri(ri), .ro_(ro_), .prog_(prog_),
    .ld_dat(ld_dat), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_done(ld_done), .marval(marval), .memval(memval)
`ifdef LDR_CKSUM_EN
    , .ld_cksum(ld_cksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mar(input logic [3:0] a);
    tb_drv = 1'b1;
    tb_val = {4'h0, a};
    mi = 1'b1;
    tick();
    mi = 1'b0;
    tb_drv = 1'b0;
  endtask

  task automatic read_at(input string tag, input logic [3:0] a, input logic [7:0] exp);
    set_mar(a);
    chk(tag, {24'h0, memval}, {24'h0, exp});
  endtask

  initial begin
    #12;
    chk("rst_ready", {31'h0, ld_ready}, 0);
    chk("rst_done", {31'h0, ld_done}, 0);
    chk("rst_mar", {28'h0, marval}, 0);
`ifdef LDR_CKSUM_EN
    chk("rst_cksum", {24'h0, ld_cksum}, 0);
`endif
    tb_drv = 1'b1; tb_val = 8'hA5; #1;
    chk("rst_bus_hiz", {24'h0, bus}, 32'hA5);
    clr_ = 1'b1;
    tb_val = 8'h1E; mi = 1'b1;
    tick();
    mi = 1'b0;
    chk("run_mar", {28'h0, marval}, 32'hE);
    tb_val = 8'h3F; ri = 1'b1;
    tick();
    ri = 1'b0; tb_drv = 1'b0;
    chk("run_write", {24'h0, memval}, 32'h3F);
    ro_ = 1'b0; #1;
    chk("run_ro_drive", {24'h0, bus}, 32'h3F);
    ro_ = 1'b1; tb_drv = 1'b1; tb_val = 8'h00; #1;
    chk("run_ro_hiz", {24'h0, bus}, 32'h00);
    tb_drv = 1'b0;

    prog_ = 1'b0; #1;
    chk("ready_before_edge", {31'h0, ld_ready}, 0);
    tick();
    chk("ready_after_prog", {31'h0, ld_ready}, 1);
    ld_valid = 1'b1; ld_dat = 8'h1E;
    tick();
    ld_dat = 8'h2F;
    tick();
    ld_dat = 8'hE0; ld_last = 1'b1;
    chk("done_before_last", {31'h0, ld_done}, 0);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("stream_done", {31'h0, ld_done}, 1);
    chk("stream_ready_low", {31'h0, ld_ready}, 0);
    chk("stream_mar_held", {28'h0, marval}, 32'hE);
`ifdef LDR_CKSUM_EN
    chk("stream_cksum", {24'h0, ld_cksum}, 32'h2D);
`endif
    prog_ = 1'b1;
    tick();
    chk("stream_done_clear", {31'h0, ld_done}, 0);
    read_at("stream_m0", 4'd0, 8'h1E);
    read_at("stream_m1", 4'd1, 8'h2F);
    read_at("stream_m2", 4'd2, 8'hE0);
    read_at("stream_mE", 4'hE, 8'h3F);

    prog_ = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      ld_valid = 1'b1; ld_dat = 8'h40 + 8'(i);
      if (i == 15) chk("full_ready_w15", {31'h0, ld_ready}, 1);
      tick();
    end
    chk("full_done", {31'h0, ld_done}, 1);
    chk("full_ready_low", {31'h0, ld_ready}, 0);
    ld_dat = 8'hFF;
    tick();
    ld_valid = 1'b0;
`ifdef LDR_CKSUM_EN
    chk("full_cksum", {24'h0, ld_cksum}, 32'h78);
`endif
    prog_ = 1'b1;
    tick();
`ifdef LDR_CKSUM_EN
    chk("cksum_held_run", {24'h0, ld_cksum}, 32'h78);
`endif
    read_at("full_m0", 4'd0, 8'h40);
    read_at("full_m7", 4'd7, 8'h47);
    read_at("full_mF", 4'hF, 8'h4F);

    prog_ = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      ld_valid = (i % 2) == 0;
      ld_dat = 8'hA0 + 8'(i / 2);
      tick();
    end
    ld_valid = 1'b0; prog_ = 1'b1;
    tick();
    chk("abandon_done", {31'h0, ld_done}, 0);
    chk("abandon_ready", {31'h0, ld_ready}, 0);
    read_at("abandon_m0", 4'd0, 8'hA0);
    read_at("abandon_m4", 4'd4, 8'hA4);
    read_at("abandon_m5", 4'd5, 8'h45);

    set_mar(4'd3);
    prog_ = 1'b0;
    tick();
    mi = 1'b1; ri = 1'b1; ro_ = 1'b0; tb_drv = 1'b1; tb_val = 8'h77; #1;
    chk("prog_bus_hiz", {24'h0, bus}, 32'h77);
    tick();
    tick();
    mi = 1'b0; ri = 1'b0; ro_ = 1'b1; tb_drv = 1'b0; prog_ = 1'b1;
    tick();
    chk("prog_mar_held", {28'h0, marval}, 32'h3);
    chk("prog_mem_held", {24'h0, memval}, 32'hA3);

    set_mar(4'd2);
    tb_drv = 1'b1; tb_val = 8'h55; mi = 1'b1; ri = 1'b1;
    tick();
    mi = 1'b0; ri = 1'b0; tb_drv = 1'b0;
    chk("mi_ri_mar", {28'h0, marval}, 32'h5);
    chk("mi_ri_m5", {24'h0, memval}, 32'h45);
    read_at("mi_ri_m2", 4'd2, 8'h55);

    prog_ = 1'b0;
    tick();
    ld_valid = 1'b1; ld_dat = 8'hC0;
    tick();
    ld_dat = 8'hC1;
    tick();
    ld_valid = 1'b0;
    chk("clr_ready_pre", {31'h0, ld_ready}, 1);
    #2 clr_ = 1'b0;
    #1;
    chk("clr_ready_drop", {31'h0, ld_ready}, 0);
    chk("clr_mar", {28'h0, marval}, 0);
`ifdef LDR_CKSUM_EN
    chk("clr_cksum", {24'h0, ld_cksum}, 0);
`endif
    clr_ = 1'b1; prog_ = 1'b1;
    tick();
    chk("clr_state_run", {31'h0, ld_ready}, 0);
    read_at("clr_m0", 4'd0, 8'hC0);
    read_at("clr_m1", 4'd1, 8'hC1);
    read_at("clr_m2", 4'd2, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
